mpeg_video_header_parser: RTL and testbench

- Byte-serial MPEG-1 video elementary-stream header parser; the next generation of the start-code decoder in the FMV path.
- Finds `00 00 01 xx` start codes, decodes the full sequence, GOP and picture header fields, and optionally reports slice start codes.
- Decoded events go through a parametrised show-ahead FIFO with a valid/ready handshake, so the FMV control logic can stall without losing headers.
- Sits between the MPEG demux byte output and the FMV decoder control / timecode logic.

---
 rtl/mpeg_video_header_parser.sv | 230 +++++++++++++++++++++++
 tb/tb_mpeg_video_header_parser.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mpeg_video_header_parser.sv
// rtl/mpeg_video_header_parser.sv - byte-serial MPEG-1 video header parser with event FIFO
//
// Purpose:
//   Finds 00 00 01 xx start codes in an MPEG-1 video elementary stream.
//   Decodes sequence, GOP and picture headers into events.
//   Events are queued in a show-ahead FIFO with a valid/ready handshake.
//
// Optional feature macro: MPEG_HDR_SLICE_EVT_EN
//   When defined, slice start codes (01..AF) push SLICE events.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   mpeg_data, data_valid  input byte stream (no backpressure)
//   evt_valid, evt_ready   event FIFO head handshake
//   evt_type, evt_payload  head entry: 0 SEQ, 1 GOP, 2 PIC, 3 SLICE
//   seq_hsize/vsize/rate   last decoded sequence header fields
//   timecode               last GOP timecode {0, drop, hours, min, sec, pic}
//   overflow               sticky flag: an event was dropped because the FIFO was full
module mpeg_video_header_parser #(
  parameter int EVT_DEPTH = 4,
  parameter int PIC_CNT_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  mpeg_data,
  input  logic        data_valid,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [1:0]  evt_type,
  output logic [31:0] evt_payload,
  output logic [11:0] seq_hsize,
  output logic [11:0] seq_vsize,
  output logic [3:0]  seq_rate,
  output logic [24:0] timecode,
  output logic        overflow
);

  localparam int AW = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_Z1, S_Z2, S_CODE,
    S_SEQ0, S_SEQ1, S_SEQ2, S_SEQ3,
    S_GOP0, S_GOP1, S_GOP2, S_GOP3,
    S_PIC0, S_PIC1
  } state_t;

  state_t               r_state;
  logic [7:0]           r_b0;
  logic [7:0]           r_b1;
  logic [7:0]           r_b2;
  logic [PIC_CNT_W-1:0] r_pic_cnt;
  logic [11:0]          r_seq_hsize;
  logic [11:0]          r_seq_vsize;
  logic [3:0]           r_seq_rate;
  logic [24:0]          r_timecode;

  logic                 w_push;
  logic [1:0]           w_push_type;
  logic [31:0]          w_push_payload;
  logic [31:0]          w_pic_payload;

  // Picture payload is {zero-pad, pic_cnt, ptype, tref}; PIC_CNT_W must stay <= 19.
  assign w_pic_payload = 32'({r_pic_cnt, mpeg_data[5:3], r_b0, mpeg_data[7:6]});

  // Event generation on the final byte of each header.
  always_comb begin
    w_push         = 1'b0;
    w_push_type    = 2'd0;
    w_push_payload = 32'd0;
    if (data_valid) begin
      case (r_state)
        S_SEQ3: begin
          // {hsize, vsize, aspect, rate} is exactly the four header bytes in order.
          w_push         = 1'b1;
          w_push_type    = 2'd0;
          w_push_payload = {r_b0, r_b1, r_b2, mpeg_data};
        end
        S_GOP3: begin
          // Drop the marker bit b1[3]; the remaining bits pack contiguously.
          w_push         = 1'b1;
          w_push_type    = 2'd1;
          w_push_payload = {6'd0, r_b0, r_b1[7:4], r_b1[2:0], r_b2, mpeg_data[7:5]};
        end
        S_PIC1: begin
          w_push         = 1'b1;
          w_push_type    = 2'd2;
          w_push_payload = w_pic_payload;
        end
`ifdef MPEG_HDR_SLICE_EVT_EN
        S_CODE: begin
          if (mpeg_data >= 8'h01 && mpeg_data <= 8'hAF) begin
            w_push         = 1'b1;
            w_push_type    = 2'd3;
            w_push_payload = {24'd0, mpeg_data};
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Start-code / header FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_b0        <= 8'd0;
      r_b1        <= 8'd0;
      r_b2        <= 8'd0;
      r_pic_cnt   <= '0;
      r_seq_hsize <= 12'd0;
      r_seq_vsize <= 12'd0;
      r_seq_rate  <= 4'd0;
      r_timecode  <= 25'd0;
    end else if (data_valid) begin
      case (r_state)
        S_IDLE: r_state <= (mpeg_data == 8'h00) ? S_Z1 : S_IDLE;
        S_Z1:   r_state <= (mpeg_data == 8'h00) ? S_Z2 : S_IDLE;
        S_Z2: begin
          if (mpeg_data == 8'h00)      r_state <= S_Z2;
          else if (mpeg_data == 8'h01) r_state <= S_CODE;
          else                         r_state <= S_IDLE;
        end
        S_CODE: begin
          case (mpeg_data)
            8'hB3:   r_state <= S_SEQ0;
            8'hB8:   r_state <= S_GOP0;
            8'h00:   r_state <= S_PIC0;
            default: r_state <= S_IDLE;
          endcase
        end
        S_SEQ0: begin r_b0 <= mpeg_data; r_state <= S_SEQ1; end
        S_SEQ1: begin r_b1 <= mpeg_data; r_state <= S_SEQ2; end
        S_SEQ2: begin r_b2 <= mpeg_data; r_state <= S_SEQ3; end
        S_SEQ3: begin
          r_seq_hsize <= {r_b0, r_b1[7:4]};
          r_seq_vsize <= {r_b1[3:0], r_b2};
          r_seq_rate  <= mpeg_data[3:0];
          r_state     <= S_IDLE;
        end
        S_GOP0: begin r_b0 <= mpeg_data; r_state <= S_GOP1; end
        S_GOP1: begin r_b1 <= mpeg_data; r_state <= S_GOP2; end
        S_GOP2: begin r_b2 <= mpeg_data; r_state <= S_GOP3; end
        S_GOP3: begin
          r_timecode <= {1'b0, r_b0, r_b1[7:4], r_b1[2:0], r_b2, mpeg_data[7]};
          r_pic_cnt  <= '0;
          r_state    <= S_IDLE;
        end
        S_PIC0: begin r_b0 <= mpeg_data; r_state <= S_PIC1; end
        S_PIC1: begin
          // Counts pictures even when the event itself is dropped on overflow.
          if (r_pic_cnt != '1) r_pic_cnt <= r_pic_cnt + PIC_CNT_W'(1);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign seq_hsize = r_seq_hsize;
  assign seq_vsize = r_seq_vsize;
  assign seq_rate  = r_seq_rate;
  assign timecode  = r_timecode;

  // Event FIFO: storage plus a registered copy of the head entry.
  logic [33:0]   r_mem [EVT_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic [1:0]    r_evt_type;
  logic [31:0]   r_evt_payload;

  logic          w_full;
  logic          w_pop;
  logic          w_push_ok;
  logic [AW-1:0] w_rd_next;

  assign w_full    = (r_count == (AW+1)'(EVT_DEPTH));
  assign w_pop     = (r_count != '0) && evt_ready;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_rd_next = r_rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= {w_push_type, w_push_payload};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_evt_type    <= 2'd0;
      r_evt_payload <= 32'd0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= w_rd_next;
      if (w_push_ok && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push_ok && w_pop) r_count <= r_count - (AW+1)'(1);
      if (w_push && !w_push_ok) r_overflow <= 1'b1;

      // Head register: load the entry that will be at the head next cycle;
      // when the FIFO drains it keeps the last head value.
      if (r_count == '0) begin
        if (w_push_ok) begin
          r_evt_type    <= w_push_type;
          r_evt_payload <= w_push_payload;
        end
      end else if (w_pop) begin
        if (r_count == (AW+1)'(1)) begin
          if (w_push_ok) begin
            r_evt_type    <= w_push_type;
            r_evt_payload <= w_push_payload;
          end
        end else begin
          r_evt_type    <= r_mem[w_rd_next][33:32];
          r_evt_payload <= r_mem[w_rd_next][31:0];
        end
      end
    end
  end

  assign evt_valid   = (r_count != '0);
  assign evt_type    = r_evt_type;
  assign evt_payload = r_evt_payload;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_mpeg_video_header_parser.sv
// tb/tb_mpeg_video_header_parser.sv - directed self-checking bench for mpeg_video_header_parser
module tb_mpeg_video_header_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  mpeg_data;
  logic        data_valid;
  logic        evt_valid;
  logic        evt_ready;
  logic [1:0]  evt_type;
  logic [31:0] evt_payload;
  logic [11:0] seq_hsize;
  logic [11:0] seq_vsize;
  logic [3:0]  seq_rate;
  logic [24:0] timecode;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic gap_en = 1'b0;

  always #5 clk = ~clk;

  mpeg_video_header_parser #(.EVT_DEPTH(4), .PIC_CNT_W(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .mpeg_data   (mpeg_data),
    .data_valid  (data_valid),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_type    (evt_type),
    .evt_payload (evt_payload),
    .seq_hsize   (seq_hsize),
    .seq_vsize   (seq_vsize),
    .seq_rate    (seq_rate),
    .timecode    (timecode),
    .overflow    (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the byte is taken at the following posedge.
  task automatic send_byte(input logic [7:0] b);
    mpeg_data  = b;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    if (gap_en) begin
      mpeg_data = 8'h00;
      @(negedge clk);
    end
  endtask

  task automatic send_start(input logic [7:0] code);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(code);
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    send_byte(a);
    send_byte(b);
    send_byte(c);
    send_byte(d);
  endtask

  task automatic send_pic(input logic [9:0] tref, input logic [2:0] ptype);
    send_start(8'h00);
    send_byte(tref[9:2]);
    send_byte({tref[1:0], ptype, 3'b000});
  endtask

  function automatic logic [31:0] pic_exp(input int cnt, input int ptype, input int tref);
    return (32'(cnt) << 13) | (32'(ptype) << 10) | 32'(tref);
  endfunction

  task automatic expect_evt(input string tag, input logic [1:0] t, input logic [31:0] p);
    int n = 0;
    while (!evt_valid && n < 16) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(evt_valid), 32'd1);
    if (evt_valid) begin
      check({tag, "_type"}, 32'(evt_type), 32'(t));
      check({tag, "_payload"}, evt_payload, p);
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
    end
  endtask

  task automatic expect_none(input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_noevt"}, 32'(evt_valid), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    mpeg_data  = 8'h00;
    data_valid = 1'b0;
    evt_ready  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_type", 32'(evt_type), 32'd0);
    check("rst_payload", evt_payload, 32'd0);
    check("rst_hsize", 32'(seq_hsize), 32'd0);
    check("rst_vsize", 32'(seq_vsize), 32'd0);
    check("rst_rate", 32'(seq_rate), 32'd0);
    check("rst_timecode", 32'(timecode), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Sequence header; event must be visible one clock after the last byte.
    send_start(8'hB3);
    send4(8'h16, 8'h00, 8'hF0, 8'hC4);
    check("seq_latency", 32'(evt_valid), 32'd1);
    check("seq_hsize", 32'(seq_hsize), 32'h160);
    check("seq_vsize", 32'(seq_vsize), 32'h0F0);
    check("seq_rate", 32'(seq_rate), 32'd4);
    expect_evt("seq", 2'd0, 32'h1600F0C4);
    check("seq_empty", 32'(evt_valid), 32'd0);
    check("seq_hold_type", 32'(evt_type), 32'd0);
    check("seq_hold_payload", evt_payload, 32'h1600F0C4);

    // GOP with an extra leading zero in the start code.
    send_byte(8'h00);
    send_start(8'hB8);
    send4(8'h00, 8'h08, 8'h00, 8'h40);
    expect_evt("gop0", 2'd1, 32'h0000_0002);
    check("gop0_timecode", 32'(timecode), 32'd0);

    send_pic(10'd0, 3'd1);
    send_pic(10'd1, 3'd2);
    expect_evt("pic_i", 2'd2, 32'h0000_0400);
    expect_evt("pic_p", 2'd2, 32'h0000_2801);

    // Non-zero GOP with idle cycles between bytes.
    gap_en = 1'b1;
    send_start(8'hB8);
    send4(8'h8E, 8'hDB, 8'hC6, 8'h20);
    gap_en = 1'b0;
    expect_evt("gop1", 2'd1, {6'd0, 1'b1, 5'd3, 6'd45, 6'd30, 6'd12, 1'b0, 1'b1});
    check("gop1_timecode", 32'(timecode), 32'({1'b0, 1'b1, 5'd3, 6'd45, 6'd30, 6'd12}));

    send_pic(10'h2C5, 3'd3);
    expect_evt("pic_cnt_clr", 2'd2, 32'h0000_0EC5);

    // Backpressure: five pictures into a four-entry FIFO.
    for (int i = 0; i < 5; i++) send_pic(10'(10 + i), 3'd3);
    check("bp_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) expect_evt($sformatf("bp%0d", i), 2'd2, pic_exp(1 + i, 3, 10 + i));
    check("bp_drained", 32'(evt_valid), 32'd0);
    check("bp_hold_payload", evt_payload, pic_exp(4, 3, 13));

    // Dropped picture still counted; maximal tref.
    send_pic(10'h3FF, 3'd7);
    expect_evt("pic_after_drop", 2'd2, pic_exp(6, 7, 10'h3FF));

    // Aborted prefix and non-header codes.
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h02);
    expect_none("abort_02");
    send_start(8'hB0);
    expect_none("code_b0");

    // Reset in the middle of a sequence header.
    send_start(8'hB3);
    send_byte(8'h16);
    send_byte(8'h00);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_hsize", 32'(seq_hsize), 32'd0);
    check("mid_rst_timecode", 32'(timecode), 32'd0);
    send_byte(8'hF0);
    send_byte(8'hC4);
    expect_none("mid_rst");
    gap_en = 1'b1;
    send_start(8'hB3);
    send4(8'h28, 8'h01, 8'hE0, 8'h33);
    gap_en = 1'b0;
    check("seq2_hsize", 32'(seq_hsize), 32'h280);
    check("seq2_vsize", 32'(seq_vsize), 32'h1E0);
    check("seq2_rate", 32'(seq_rate), 32'd3);
    expect_evt("seq2", 2'd0, 32'h2801E033);

    // Slice start codes.
    send_start(8'h05);
`ifdef MPEG_HDR_SLICE_EVT_EN
    expect_evt("slice_05", 2'd3, 32'h0000_0005);
`else
    expect_none("slice_05");
`endif
    send_start(8'hAF);
`ifdef MPEG_HDR_SLICE_EVT_EN
    expect_evt("slice_af", 2'd3, 32'h0000_00AF);
`else
    expect_none("slice_af");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
